// File: rtl/montgomery_r4_pkg.sv
// Shared types and helpers for the radix-4 Montgomery multiplier.
package montgomery_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    LOOP,
    SUB,
    DONE
  } state_e;

  function automatic int unsigned acc_w(input int unsigned n);
    return n + 3;
  endfunction

  function automatic int unsigned mul_w(input int unsigned n);
    return n + 2;
  endfunction

  // q = -C*M^-1 mod 4; for odd M, M^-1 == M (mod 4).
  function automatic logic [1:0] mont_q(input logic [1:0] c_lo, input logic [1:0] m_lo);
    logic [1:0] p;
    p = c_lo * m_lo;
    return 2'd0 - p;
  endfunction

endpackage

// File: rtl/montgomery_r4_csel_add.sv
// Adds one of four precomputed multiples {0, X, 2X, 3X} to the accumulator.
module mont_r4_csel_add #(
  parameter int unsigned ACC_W = 11,
  parameter int unsigned MUL_W = 10
) (
  input  logic [1:0]       sel,
  input  logic [MUL_W-1:0] x0,
  input  logic [MUL_W-1:0] x1,
  input  logic [MUL_W-1:0] x2,
  input  logic [MUL_W-1:0] x3,
  input  logic [ACC_W-1:0] acc,
  output logic [ACC_W-1:0] sum_c
);

  logic [MUL_W-1:0] pick;

  always_comb begin
    pick = x0;
    case (sel)
      2'd1:    pick = x1;
      2'd2:    pick = x2;
      2'd3:    pick = x3;
      default: pick = x0;
    endcase
    sum_c = acc + ACC_W'(pick);
  end

endmodule

// File: rtl/montgomery_r4.sv
// Radix-4 Montgomery multiplier: result = A*B*2^-N mod M, fully reduced.
module montgomery_r4
  import montgomery_pkg::*;
#(
  parameter int unsigned N = 1024
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_m,
  output logic [N-1:0] result,
  output logic         done,
  output logic         busy
);

  localparam int unsigned ACC_W  = acc_w(N);
  localparam int unsigned MUL_W  = mul_w(N);
  localparam int unsigned DIGITS = N / 2;
  localparam int unsigned CNT_W  = $clog2(DIGITS);

  state_e           state_q, state_d;
  logic [N-1:0]     a_q, a_d, b_q, b_d, m_q, m_d;
  logic [MUL_W-1:0] b2_q, b2_d, b3_q, b3_d, m2_q, m2_d, m3_q, m3_d;
  logic [ACC_W-1:0] c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic [N-1:0]     result_q, result_d;
  logic             done_q, done_d, busy_q, busy_d;

  logic [1:0]       sel_c;
  logic [MUL_W-1:0] x1_c, x2_c, x3_c;
  logic [ACC_W-1:0] sum_c;

  // Phase 0 adds a multiple of B by the next A digit; phase 1 adds q*M.
  always_comb begin
    sel_c = phase_q ? mont_q(c_q[1:0], m_q[1:0]) : a_q[1:0];
    x1_c  = phase_q ? MUL_W'(m_q) : MUL_W'(b_q);
    x2_c  = phase_q ? m2_q : b2_q;
    x3_c  = phase_q ? m3_q : b3_q;
  end

  mont_r4_csel_add #(
    .ACC_W(ACC_W),
    .MUL_W(MUL_W)
  ) u_csel_add (
    .sel  (sel_c),
    .x0   ('0),
    .x1   (x1_c),
    .x2   (x2_c),
    .x3   (x3_c),
    .acc  (c_q),
    .sum_c(sum_c)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    b2_d     = b2_q;
    b3_d     = b3_q;
    m2_d     = m2_q;
    m3_d     = m3_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = in_a;
          b_d     = in_b;
          m_d     = in_m;
          c_d     = '0;
          cnt_d   = '0;
          phase_d = 1'b0;
          state_d = PREP;
        end
      end
      PREP: begin
        b2_d    = MUL_W'({b_q, 1'b0});
        b3_d    = MUL_W'(b_q) + MUL_W'({b_q, 1'b0});
        m2_d    = MUL_W'({m_q, 1'b0});
        m3_d    = MUL_W'(m_q) + MUL_W'({m_q, 1'b0});
        state_d = LOOP;
      end
      LOOP: begin
        if (!phase_q) begin
          c_d     = sum_c;
          a_d     = a_q >> 2;
          phase_d = 1'b1;
        end else begin
          c_d     = sum_c >> 2;
          phase_d = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DIGITS - 1)) state_d = SUB;
        end
      end
      SUB: begin
        if (c_q >= ACC_W'(m_q)) result_d = N'(c_q - ACC_W'(m_q));
        else                    result_d = c_q[N-1:0];
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      b2_q     <= '0;
      b3_q     <= '0;
      m2_q     <= '0;
      m3_q     <= '0;
      c_q      <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      b2_q     <= b2_d;
      b3_q     <= b3_d;
      m2_q     <= m2_d;
      m3_q     <= m3_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_montgomery_r4.sv
// Self-checking bench: N=8 and N=1024 instances against a modular-arithmetic model.
module tb_montgomery_r4;

  localparam int unsigned NS = 8;
  localparam int unsigned NL = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn, start_s, start_l;
  logic [NS-1:0] a_s, b_s, m_s, res_s;
  logic [NL-1:0] a_l, b_l, m_l, res_l;
  logic          done_s, busy_s, done_l, busy_l;

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;

  montgomery_r4 #(.N(NS)) u_dut_s (
    .clk(clk), .resetn(resetn), .start(start_s),
    .in_a(a_s), .in_b(b_s), .in_m(m_s),
    .result(res_s), .done(done_s), .busy(busy_s)
  );

  montgomery_r4 #(.N(NL)) u_dut_l (
    .clk(clk), .resetn(resetn), .start(start_l),
    .in_a(a_l), .in_b(b_l), .in_m(m_l),
    .result(res_l), .done(done_l), .busy(busy_l)
  );

  task automatic check_eq(input string tag, input logic [NL-1:0] got, input logic [NL-1:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got ..%h expected ..%h", tag, got[191:0], exp[191:0]);
    end
  endtask

  // (a*b mod m) halved mod m n times, i.e. multiplied by 2^-n mod m.
  function automatic logic [NL-1:0] ref_mont(input logic [NL-1:0] a, input logic [NL-1:0] b,
                                            input logic [NL-1:0] m, input int n);
    logic [2*NL-1:0] p;
    logic [NL:0]     y;
    p = ({{NL{1'b0}}, a} * {{NL{1'b0}}, b}) % {{NL{1'b0}}, m};
    y = p[NL:0];
    for (int j = 0; j < n; j++) begin
      if (y[0]) y = y + {1'b0, m};
      y = y >> 1;
    end
    return y[NL-1:0];
  endfunction

  // Issues one op and returns result, start-to-done latency and busy violations.
  task automatic run_op(input bit big, input logic [NL-1:0] a, input logic [NL-1:0] b,
                        input logic [NL-1:0] m, output logic [NL-1:0] res,
                        output int lat, output int busy_bad);
    @(negedge clk);
    if (big) begin
      a_l = a; b_l = b; m_l = m; start_l = 1'b1;
    end else begin
      a_s = a[NS-1:0]; b_s = b[NS-1:0]; m_s = m[NS-1:0]; start_s = 1'b1;
    end
    @(negedge clk);
    start_s = 1'b0;
    start_l = 1'b0;
    a_s = NS'($urandom);
    b_s = NS'($urandom);
    m_s = NS'($urandom);
    a_l = '1;
    lat = -1;
    busy_bad = 0;
    for (int c = 1; c <= int'(NL) + 20; c++) begin
      if (c > 1) @(negedge clk);
      if (!(big ? busy_l : busy_s)) busy_bad++;
      if (big ? done_l : done_s) begin
        lat = c;
        break;
      end
    end
    res = big ? res_l : NL'(res_s);
    @(negedge clk);
    if (big ? (busy_l | done_l) : (busy_s | done_s)) busy_bad++;
  endtask

  logic [NL-1:0] res, a, b, m;
  int            lat, bb, seen;
  int            dq[$];

  initial begin
    resetn = 1'b0; start_s = 1'b0; start_l = 1'b0;
    a_s = '0; b_s = '0; m_s = '0; a_l = '0; b_l = '0; m_l = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_result_8", NL'(res_s), '0);
    check_eq("rst_done_busy_8", NL'({done_s, busy_s}), '0);
    check_eq("rst_result_1024", res_l, '0);
    check_eq("rst_done_busy_1024", NL'({done_l, busy_l}), '0);
    resetn = 1'b1;

    run_op(1'b0, 5, 7, 13, res, lat, bb);
    check_eq("dir_5_7_13", res, 1);
    check_eq("dir_latency", NL'(lat), 11);
    check_eq("dir_busy", NL'(bb), 0);
    run_op(1'b0, 1, 1, 13, res, lat, bb);
    check_eq("dir_1_1_13", res, 3);
    run_op(1'b0, 0, 12, 13, res, lat, bb);
    check_eq("dir_0_12_13", res, 0);
    run_op(1'b0, 254, 254, 255, res, lat, bb);
    check_eq("dir_final_sub", res, 1);
    check_eq("dir_final_sub_model", res, ref_mont(254, 254, 255, NS));

    // Reset for one cycle while in LOOP.
    @(negedge clk);
    a_s = 5; b_s = 7; m_s = 13; start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    repeat (4) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_s) seen++;
      if (busy_s) seen++;
    end
    check_eq("midrst_no_done_busy", NL'(seen), 0);
    check_eq("midrst_result", NL'(res_s), 0);
    run_op(1'b0, 9, 11, 13, res, lat, bb);
    check_eq("midrst_fresh", res, ref_mont(9, 11, 13, NS));
    check_eq("midrst_fresh_lat", NL'(lat), 11);

    // Reset and start together: reset wins.
    @(negedge clk);
    resetn = 1'b0; start_s = 1'b1;
    @(negedge clk);
    resetn = 1'b1; start_s = 1'b0;
    @(negedge clk);
    check_eq("rst_vs_start_busy", NL'(busy_s), 0);

    // Start held high: one done per accepted start, re-accepted after DONE.
    @(negedge clk);
    a_s = 5; b_s = 7; m_s = 13; start_s = 1'b1;
    dq.delete();
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      if (done_s) dq.push_back(c);
    end
    start_s = 1'b0;
    check_eq("held_done_count", NL'(dq.size()), 3);
    if (dq.size() == 3) begin
      check_eq("held_done_0", NL'(dq[0]), 11);
      check_eq("held_done_1", NL'(dq[1]), 23);
      check_eq("held_done_2", NL'(dq[2]), 35);
    end
    check_eq("held_result", NL'(res_s), 1);
    repeat (2) @(negedge clk);
    check_eq("held_idle", NL'({done_s, busy_s}), 0);

    for (int t = 0; t < 100; t++) begin
      int mi, ai, bi;
      mi = int'($urandom_range(255, 3)) | 1;
      ai = int'($urandom_range(mi - 1, 0));
      bi = int'($urandom_range(mi - 1, 0));
      run_op(1'b0, NL'(ai), NL'(bi), NL'(mi), res, lat, bb);
      check_eq("rnd8_result", res, ref_mont(NL'(ai), NL'(bi), NL'(mi), NS));
      check_eq("rnd8_lat_busy", NL'({lat, bb}), NL'({32'd11, 32'd0}));
    end

    for (int t = 0; t < 40; t++) begin
      for (int w = 0; w < 32; w++) begin
        m[w*32 +: 32] = $urandom;
        a[w*32 +: 32] = $urandom;
        b[w*32 +: 32] = $urandom;
      end
      m[0] = 1'b1;
      a = a % m;
      b = b % m;
      run_op(1'b1, a, b, m, res, lat, bb);
      check_eq("rnd1024_result", res, ref_mont(a, b, m, NL));
      check_eq("rnd1024_lat", NL'(lat), 1027);
      check_eq("rnd1024_busy", NL'(bb), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
